// File: rtl/dnn_mac_scheduler.sv
// dnn_mac_scheduler: 4-4-2 ReLU network evaluated on one shared
// multiplier and accumulator, one multiply-accumulate per cycle.
module dnn_mac_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [19:0] x_flat,
  input  logic [79:0] w1_flat,
  input  logic [39:0] w2_flat,
  output logic [16:0] out0,
  output logic [16:0] out1,
  output logic        out_valid,
  input  logic        out_ack,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L1   = 2'd1,
    L2   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [16:0]       acc_q, acc_d;
  logic [3:0][11:0]  h_q, h_d;
  logic [3:0][4:0]   x_q, x_d;
  logic [15:0][4:0]  w1_q, w1_d;
  logic [7:0][4:0]   w2_q, w2_d;
  logic [16:0]       out0_q, out0_d;
  logic [16:0]       out1_q, out1_d;
  logic              out_valid_q, out_valid_d;

  logic              in_l1;
  logic [4:0]        x_sel;
  logic [4:0]        w_sel;
  logic [11:0]       h_sel;
  logic signed [16:0] op_a;
  logic signed [16:0] op_b;
  logic signed [16:0] prod;
  logic [16:0]       base;
  logic [16:0]       sum;
  logic [11:0]       relu;

  // Shared datapath: operand mux, multiplier and accumulator adder.
  // Layer-1 steps use x_i * w1, layer-2 steps use h_j * w2; the
  // running sum restarts whenever the low counter bits are zero.
  always_comb begin
    in_l1 = (state_q == L1);
    x_sel = x_q[cnt_q[1:0]];
    w_sel = in_l1 ? w1_q[cnt_q] : w2_q[cnt_q[2:0]];
    h_sel = h_q[cnt_q[1:0]];
    op_a  = in_l1 ? {{12{x_sel[4]}}, x_sel} : {5'b0, h_sel};
    op_b  = {{12{w_sel[4]}}, w_sel};
    prod  = op_a * op_b;
    base  = (cnt_q[1:0] == 2'd0) ? 17'd0 : acc_q;
    sum   = base + prod;
    relu  = sum[16] ? 12'd0 : sum[11:0];
  end

  // Next-state and datapath register updates for the scheduler FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    h_d         = h_q;
    x_d         = x_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    out0_d      = out0_q;
    out1_d      = out1_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x_flat;
          w1_d    = w1_flat;
          w2_d    = w2_flat;
          cnt_d   = 4'd0;
          state_d = L1;
        end
      end
      L1: begin
        acc_d = sum;
        if (cnt_q[1:0] == 2'd3) begin
          h_d[cnt_q[3:2]] = relu;
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = L2;
        end
      end
      L2: begin
        acc_d = sum;
        if (cnt_q[1:0] == 2'd3) begin
          if (cnt_q[2]) begin
            out1_d = sum;
          end else begin
            out0_d = sum;
          end
        end
        if (cnt_q == 4'd7) begin
          cnt_d       = 4'd0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ack) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      h_q         <= '0;
      x_q         <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      out0_q      <= '0;
      out1_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      h_q         <= h_d;
      x_q         <= x_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == L1) || (state_q == L2);
  assign out0      = out0_q;
  assign out1      = out1_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dnn_mac_scheduler.sv
// tb_dnn_mac_scheduler: directed vectors with hand-computed results
// for the 4-4-2 MAC scheduler, including handshake and reset abort.
module tb_dnn_mac_scheduler;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] x_flat;
  logic [79:0] w1_flat;
  logic [39:0] w2_flat;
  logic [16:0] out0;
  logic [16:0] out1;
  logic        out_valid;
  logic        out_ack;
  logic        busy;

  int n_run;
  int n_fail;

  int x_v[4];
  int w1_v[16];
  int w2_v[8];

  dnn_mac_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_flat    (x_flat),
    .w1_flat   (w1_flat),
    .w2_flat   (w2_flat),
    .out0      (out0),
    .out1      (out1),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int s17(input logic [16:0] v);
    return int'($signed(v));
  endfunction

  task automatic pack_bus;
    for (int i = 0; i < 4; i++) x_flat[5*i +: 5] = x_v[i][4:0];
    for (int n = 0; n < 16; n++) w1_flat[5*n +: 5] = w1_v[n][4:0];
    for (int n = 0; n < 8; n++) w2_flat[5*n +: 5] = w2_v[n][4:0];
  endtask

  task automatic load_nominal;
    x_v  = '{4, 2, 4, 1};
    w1_v = '{3, 2, 13, -6, -9, 1, -4, 14,
             3, 6, -15, 15, 9, -10, 15, -10};
    w2_v = '{0, -1, 3, -11, -12, -15, -15, 6};
    pack_bus();
  endtask

  task automatic load_const(input int xv, input int w1c, input int w2c);
    for (int i = 0; i < 4; i++) x_v[i] = xv;
    for (int n = 0; n < 16; n++) w1_v[n] = w1c;
    for (int n = 0; n < 8; n++) w2_v[n] = w2c;
    pack_bus();
  endtask

  task automatic scramble;
    x_flat  = 20'hABCDE;
    w1_flat = {5{16'h5A3C}};
    w2_flat = {5{8'hC7}};
  endtask

  // Capture edge assumed already armed (in_valid=1 in IDLE).
  task automatic run_vec(input string tag, input int e0, input int e1);
    int lat;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
    chk({tag, "_busy"}, int'(busy), 1);
    chk({tag, "_rdy"}, int'(in_ready), 0);
    lat = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = e;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 24);
    chk({tag, "_o0"}, s17(out0), e0);
    chk({tag, "_o1"}, s17(out1), e1);
    chk({tag, "_busy_done"}, int'(busy), 0);
  endtask

  task automatic ack;
    out_ack = 1'b1;
    @(posedge clk);
    #1;
    out_ack = 1'b0;
  endtask

  initial begin
    n_run    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    out_ack  = 1'b0;
    x_flat   = '0;
    w1_flat  = '0;
    w2_flat  = '0;
    #12;
    chk("rst_rdy", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_vld", int'(out_valid), 0);
    chk("rst_o0", s17(out0), 0);
    chk("rst_o1", s17(out1), 0);
    @(negedge clk);
    rst = 1'b0;

    load_nominal();
    in_valid = 1'b1;
    run_vec("nom", -726, -348);

    in_valid = 1'b1;
    load_const(-16, -16, -16);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (c == 9) begin
        chk("hold_vld", int'(out_valid), 1);
        chk("hold_rdy", int'(in_ready), 0);
        chk("hold_o0", s17(out0), -726);
        chk("hold_o1", s17(out1), -348);
      end
    end
    in_valid = 1'b0;
    ack();
    chk("ack_rdy", int'(in_ready), 1);
    chk("ack_vld", int'(out_valid), 0);
    chk("ack_keep_o0", s17(out0), -726);

    in_valid = 1'b1;
    run_vec("ext", -65536, -65536);
    ack();

    load_const(1, -1, 7);
    in_valid = 1'b1;
    run_vec("relu", 0, 0);
    ack();

    load_const(-16, -16, -16);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (21) @(posedge clk);
    #2;
    chk("mid_o0", s17(out0), -65536);
    rst = 1'b1;
    #1;
    chk("abort_o0", s17(out0), 0);
    chk("abort_o1", s17(out1), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_rdy", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    load_nominal();
    in_valid = 1'b1;
    run_vec("rerun", -726, -348);
    ack();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
